regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the multicycle RISC-V core: configurable data width, depth and read-port count, two write ports with fixed priority, write-to-read bypass, and a hardware clear engine that zeroes the array after reset or on request. It sits between the decode stage, which drives the read ports, and the writeback stage, which drives the write ports. Internal storage is plain (non-reset) memory, so clearing is done sequentially.

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of 2, >= 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.
- wb_clk  in  1  clock; all state updates on the rising edge.
- wb_rst_n  in  1  reset; asynchronous assert, active-low.
- we0, we1  in  1 each  write enables for ports 0 and 1.
- waddr0, waddr1  in  AW each  write addresses.
- wdata0, wdata1  in  XLEN each  write data.
- raddr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN]; combinational.
- clr_req  in  1  single-cycle pulse that requests a full clear.
- ready  out  1  high when the array is valid and accepts writes.
- wr_drop  out  1  registered one-cycle pulse, set when a write was discarded.

## Operation
- FSM states: CLEAR, READY.
- Reset puts the FSM in CLEAR with the clear counter cnt = 0, ready = 0 and wr_drop = 0.
- CLEAR:
  - Each cycle, write 0 to array[cnt] and increment cnt.
  - When cnt == NREGS-1, the last location is written and the FSM moves to READY with cnt = 0.
  - Total time in CLEAR is exactly NREGS cycles.
  - All reads return 0.
  - Any we0/we1 is discarded, and wr_drop = 1 on the next cycle.
  - clr_req is ignored.
- READY:
  - When we0 is set, array[waddr0] <= wdata0. When we1 is set, array[waddr1] <= wdata1.
  - If waddr0 == waddr1 and both enables are set, port 1 wins. This is not a drop.
  - When ZERO_REG = 1, writes to address 0 are silently ignored. This is not a drop.
  - clr_req moves the FSM to CLEAR on the next edge. A write in that same cycle is still performed, although the following clear overwrites it.
- Read path, per port i, with a = raddr[i]:
  - If ZERO_REG and a == 0, return 0.
  - Else if not ready, return 0.
  - Else if we1 && waddr1 == a, return wdata1 (bypass).
  - Else if we0 && waddr0 == a, return wdata0 (bypass).
  - Else return array[a].
  - The bypass never forwards to address 0 when ZERO_REG = 1.
- All NRD ports are independent. The same address on several ports returns the same value.

## Timing
- Reads are zero-latency combinational. Bypass makes a same-cycle write visible on the same cycle's read.
- Writes are architecturally visible from the edge after they are presented, or immediately through the bypass.
- ready rises on the edge that completes the last clear write, i.e. NREGS edges after reset release, and falls on the edge after clr_req is accepted.
- wr_drop is high for exactly the cycle after a dropped write; consecutive drops keep it high.
- A reset asserted mid-CLEAR or mid-READY takes effect asynchronously: the FSM returns to CLEAR with cnt = 0, and the clear restarts from address 0 after release.
- cnt wraps only by the state transition; it never exceeds NREGS-1.

## Test plan
- Reset release with NREGS = 32 -> ready = 0 for 32 cycles, then 1; every address reads 0; wr_drop stays 0.
- In READY: we0, waddr0 = 5, wdata0 = 0xDEADBEEF, with raddr port 0 = 5 in the same cycle -> rdata0 = 0xDEADBEEF in that cycle (bypass), and it still reads 0xDEADBEEF after the edge.
- Both ports write address 7 (0x11111111 on port 0, 0x22222222 on port 1) -> bypass and stored value are both 0x22222222; wr_drop = 0.
- Write 0xFFFFFFFF to address 0 with ZERO_REG = 1 -> read of address 0 is 0 in the same cycle and afterwards; wr_drop = 0.
- After filling addresses 1..31 with their index, pulse clr_req and write address 3 = 0xABCD on the next cycle -> ready drops, wr_drop pulses once, and all reads are 0 after 32 cycles in CLEAR.
- Assert wb_rst_n low at clear count 10, then release -> a full 32-cycle clear restarts; ready rises only after it completes. Repeat with NRD = 4 and XLEN = 64, checking all four ports read independent addresses correctly.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Read/write/clear bus of the multi-port register file.
// The decode and writeback stages drive it as master; the register file is the slave.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                we0;
  logic                we1;
  logic [AW-1:0]       waddr0;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata0;
  logic [XLEN-1:0]     wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                clr_req;
  logic                ready;
  logic                wr_drop;

  modport master (
    output we0, we1, waddr0, waddr1, wdata0, wdata1, raddr, clr_req,
    input  rdata, ready, wr_drop
  );

  modport slave (
    input  we0, we1, waddr0, waddr1, wdata0, wdata1, raddr, clr_req,
    output rdata, ready, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with write bypass,
// two prioritised write ports, and a sequential clear engine after reset or clr_req.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready_q;
  logic            wr_drop_q;
  logic [XLEN-1:0] mem [NREGS];

  logic                w0_ok;
  logic                w1_ok;
  logic [NRD*XLEN-1:0] rd;

  // Writes to a hardwired zero register are filtered here so neither the
  // array nor the bypass ever sees them.
  always_comb begin
    w0_ok = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    w1_ok = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          wr_drop_q <= bus.we0 | bus.we1;
          if (cnt == LAST) begin
            state   <= READY;
            cnt     <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          wr_drop_q <= 1'b0;
          if (bus.clr_req) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; port 1 is written last so it wins on a collision.
  always_ff @(posedge wb_clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (w0_ok) mem[bus.waddr0] <= bus.wdata0;
      if (w1_ok) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if (!ready_q)                      return '0;
    if (w1_ok && (bus.waddr1 == a))    return bus.wdata1;
    if (w0_ok && (bus.waddr0 == a))    return bus.wdata0;
    return mem[a];
  endfunction

  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd[i*XLEN +: XLEN] = read_port(bus.raddr[i*AW +: AW]);
    end
  end

  assign bus.rdata   = rd;
  assign bus.ready   = ready_q;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32x32 two-read-port instance and a
// 32x64 four-read-port instance sharing clock and reset.
module tb_regfile_mp;
  logic wb_clk;
  logic wb_rst_n;
  int   checks;
  int   errors;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
  regfile_mp_if #(.XLEN(64), .NREGS(32), .NRD(4)) ifb ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_a (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .bus(ifa)
  );
  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(4), .ZERO_REG(1)) u_b (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .bus(ifb)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle;
    ifa.we0 = 0; ifa.we1 = 0; ifa.waddr0 = '0; ifa.waddr1 = '0;
    ifa.wdata0 = '0; ifa.wdata1 = '0; ifa.raddr = '0; ifa.clr_req = 0;
    ifb.we0 = 0; ifb.we1 = 0; ifb.waddr0 = '0; ifb.waddr1 = '0;
    ifb.wdata0 = '0; ifb.wdata1 = '0; ifb.raddr = '0; ifb.clr_req = 0;
  endtask

  task automatic test_reset;
    wb_rst_n = 0;
    idle();
    repeat (2) tick();
    checks++;
    if (ifa.ready !== 1'b0 || ifa.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b wr_drop=%b, want 0 0", ifa.ready, ifa.wr_drop);
    end
    wb_rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      ifa.raddr = {5'd5, 5'(k)};
      #1;
      checks++;
      if (ifa.ready !== 1'b0 || ifb.ready !== 1'b0 || ifa.wr_drop !== 1'b0 ||
          ifa.rdata !== 64'h0) begin
        errors++;
        $display("FAIL clear_phase k=%0d: ready=%b/%b wr_drop=%b rdata=%h, want 0 0 0 0",
                 k, ifa.ready, ifb.ready, ifa.wr_drop, ifa.rdata);
      end
      tick();
    end
    checks++;
    if (ifa.ready !== 1'b1 || ifb.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: ready=%b/%b after 32 edges, want 1", ifa.ready, ifb.ready);
    end
    for (int k = 0; k < 32; k++) begin
      ifa.raddr = {5'(31 - k), 5'(k)};
      #1;
      checks++;
      if (ifa.rdata !== 64'h0 || ifa.wr_drop !== 1'b0) begin
        errors++;
        $display("FAIL cleared_read k=%0d: rdata=%h wr_drop=%b, want 0 0", k, ifa.rdata, ifa.wr_drop);
      end
    end
  endtask

  task automatic test_bypass;
    ifa.we0 = 1; ifa.waddr0 = 5'd5; ifa.wdata0 = 32'hDEADBEEF;
    ifa.raddr = {5'd5, 5'd5};
    #2;
    checks++;
    if (ifa.rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL bypass_same_cycle: rdata=%h, want deadbeefdeadbeef", ifa.rdata);
    end
    tick();
    ifa.we0 = 0;
    #1;
    checks++;
    if (ifa.rdata[31:0] !== 32'hDEADBEEF || ifa.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL bypass_stored: rdata0=%h wr_drop=%b, want deadbeef 0", ifa.rdata[31:0], ifa.wr_drop);
    end
  endtask

  task automatic test_dual_write;
    ifa.we0 = 1; ifa.waddr0 = 5'd7; ifa.wdata0 = 32'h11111111;
    ifa.we1 = 1; ifa.waddr1 = 5'd7; ifa.wdata1 = 32'h22222222;
    ifa.raddr = {5'd5, 5'd7};
    #2;
    checks++;
    if (ifa.rdata !== {32'hDEADBEEF, 32'h22222222}) begin
      errors++;
      $display("FAIL dual_bypass: rdata=%h, want deadbeef22222222", ifa.rdata);
    end
    tick();
    ifa.we0 = 0; ifa.we1 = 0;
    #1;
    checks++;
    if (ifa.rdata[31:0] !== 32'h22222222 || ifa.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL dual_stored: rdata0=%h wr_drop=%b, want 22222222 0", ifa.rdata[31:0], ifa.wr_drop);
    end
  endtask

  task automatic test_zero_reg;
    ifa.we0 = 1; ifa.waddr0 = 5'd0; ifa.wdata0 = 32'hFFFFFFFF;
    ifa.we1 = 1; ifa.waddr1 = 5'd0; ifa.wdata1 = 32'hFFFFFFFF;
    ifa.raddr = {5'd0, 5'd0};
    #2;
    checks++;
    if (ifa.rdata !== 64'h0) begin
      errors++;
      $display("FAIL zero_reg_bypass: rdata=%h, want 0", ifa.rdata);
    end
    tick();
    ifa.we0 = 0; ifa.we1 = 0;
    #1;
    checks++;
    if (ifa.rdata !== 64'h0 || ifa.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_stored: rdata=%h wr_drop=%b, want 0 0", ifa.rdata, ifa.wr_drop);
    end
  endtask

  task automatic test_clear_req;
    for (int i = 1; i < 32; i += 2) begin
      ifa.we0 = 1; ifa.waddr0 = 5'(i); ifa.wdata0 = 32'(i);
      ifa.we1 = (i + 1 < 32); ifa.waddr1 = 5'(i + 1); ifa.wdata1 = 32'(i + 1);
      tick();
    end
    ifa.we0 = 0; ifa.we1 = 0;
    ifa.raddr = {5'd31, 5'd3};
    #1;
    checks++;
    if (ifa.rdata !== {32'd31, 32'd3}) begin
      errors++;
      $display("FAIL fill_readback: rdata=%h, want 0000001f00000003", ifa.rdata);
    end
    ifa.clr_req = 1;
    tick();
    ifa.clr_req = 0;
    ifa.we0 = 1; ifa.waddr0 = 5'd3; ifa.wdata0 = 32'hABCD;
    #1;
    checks++;
    if (ifa.ready !== 1'b0 || ifa.wr_drop !== 1'b0 || ifa.rdata !== 64'h0) begin
      errors++;
      $display("FAIL clr_accept: ready=%b wr_drop=%b rdata=%h, want 0 0 0", ifa.ready, ifa.wr_drop, ifa.rdata);
    end
    tick();
    ifa.we0 = 0;
    #1;
    checks++;
    if (ifa.wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: wr_drop=%b, want 1", ifa.wr_drop);
    end
    tick();
    checks++;
    if (ifa.wr_drop !== 1'b0 || ifa.ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: wr_drop=%b ready=%b, want 0 0", ifa.wr_drop, ifa.ready);
    end
    repeat (29) tick();
    checks++;
    if (ifa.ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_length_early: ready=%b after 31 clear edges, want 0", ifa.ready);
    end
    tick();
    checks++;
    if (ifa.ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_length: ready=%b after 32 clear edges, want 1", ifa.ready);
    end
    for (int k = 0; k < 32; k++) begin
      ifa.raddr = {5'(k), 5'(k)};
      #1;
      checks++;
      if (ifa.rdata !== 64'h0) begin
        errors++;
        $display("FAIL post_clear_read addr=%0d: rdata=%h, want 0", k, ifa.rdata);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    ifb.we0 = 1; ifb.waddr0 = 5'd4; ifb.wdata0 = 64'h1234;
    tick();
    ifb.we0 = 0;
    wb_rst_n = 0;
    #1;
    checks++;
    if (ifa.ready !== 1'b0 || ifb.ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ready: ready=%b/%b, want 0", ifa.ready, ifb.ready);
    end
    tick();
    wb_rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      ifa.we0 = (k == 3); ifa.waddr0 = 5'd9; ifa.wdata0 = 32'h99;
      ifa.we1 = (k == 4); ifa.waddr1 = 5'd10; ifa.wdata1 = 32'hAA;
      #1;
      checks++;
      if (ifa.wr_drop !== ((k == 4) || (k == 5)) || ifa.ready !== 1'b0) begin
        errors++;
        $display("FAIL consecutive_drop k=%0d: wr_drop=%b ready=%b, want %b 0",
                 k, ifa.wr_drop, ifa.ready, (k == 4) || (k == 5));
      end
      tick();
    end
    ifa.we0 = 0; ifa.we1 = 0;
    wb_rst_n = 0;
    #1;
    checks++;
    if (ifa.ready !== 1'b0 || ifa.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: ready=%b wr_drop=%b, want 0 0", ifa.ready, ifa.wr_drop);
    end
    tick();
    wb_rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (ifa.ready !== 1'b0 || ifb.ready !== 1'b0) begin
        errors++;
        $display("FAIL restart_clear k=%0d: ready=%b/%b, want 0", k, ifa.ready, ifb.ready);
      end
      tick();
    end
    ifa.raddr = {5'd10, 5'd5};
    ifb.raddr = {5'd0, 5'd0, 5'd0, 5'd4};
    #1;
    checks++;
    if (ifa.ready !== 1'b1 || ifb.ready !== 1'b1 || ifa.rdata !== 64'h0 || ifb.rdata !== 256'h0) begin
      errors++;
      $display("FAIL restart_done: ready=%b/%b rdata_a=%h rdata_b0=%h, want 1 1 0 0",
               ifa.ready, ifb.ready, ifa.rdata, ifb.rdata[63:0]);
    end
  endtask

  task automatic test_wide;
    ifb.we0 = 1; ifb.waddr0 = 5'd2;  ifb.wdata0 = 64'h0123_4567_89AB_CDEF;
    ifb.we1 = 1; ifb.waddr1 = 5'd9;  ifb.wdata1 = 64'hFEDC_BA98_7654_3210;
    tick();
    ifb.we0 = 1; ifb.waddr0 = 5'd17; ifb.wdata0 = 64'hA5A5_0000_FFFF_5A5A;
    ifb.we1 = 1; ifb.waddr1 = 5'd31; ifb.wdata1 = 64'h8000_0000_0000_0001;
    ifb.raddr = {5'd31, 5'd17, 5'd9, 5'd2};
    #2;
    checks++;
    if (ifb.rdata !== {64'h8000_0000_0000_0001, 64'hA5A5_0000_FFFF_5A5A,
                       64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL wide_bypass: rdata=%h", ifb.rdata);
    end
    tick();
    ifb.we0 = 0; ifb.we1 = 0;
    ifb.raddr = {5'd2, 5'd9, 5'd17, 5'd31};
    #1;
    checks++;
    if (ifb.rdata !== {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'hA5A5_0000_FFFF_5A5A, 64'h8000_0000_0000_0001}) begin
      errors++;
      $display("FAIL wide_stored: rdata=%h", ifb.rdata);
    end
    ifb.raddr = {5'd9, 5'd9, 5'd0, 5'd9};
    #1;
    checks++;
    if (ifb.rdata !== {64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210,
                       64'h0, 64'hFEDC_BA98_7654_3210}) begin
      errors++;
      $display("FAIL wide_same_addr: rdata=%h", ifb.rdata);
    end
    checks++;
    if (ifb.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wide_no_drop: wr_drop=%b, want 0", ifb.wr_drop);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_clear_req();
    test_reset_mid_clear();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
